// File: rtl/core_pkg.sv
// core_pkg
// Shared definitions for the branch prediction slice of the 5-stage core.
//   XLEN              : default PC width
//   SNT/WNT/WT/ST     : 2-bit saturating counter encodings
//   sat_inc2/sat_dec2 : saturating step functions for those counters
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] sat_inc2(input logic [1:0] ctr);
    return (ctr == ST) ? ST : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] ctr);
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_table.sv
// btb_table
// Direct-mapped BTB with one 2-bit direction counter per entry.
// The read port (IF side) is combinational; the write port (EX side) updates at
// posedge clk. Reset is asynchronous, active-low, and clears every entry.
// Ports:
//   clk, rstn        : clock and async active-low reset
//   rd_pc            : PC being fetched
//   rd_taken         : entry hits and its counter predicts taken
//   rd_target        : stored target on a hit, else 0
//   wr_en            : live branch resolving in EX this cycle
//   wr_pc            : PC of the resolving instruction
//   wr_taken         : resolved direction
//   wr_target        : resolved target
//   wr_inval         : drop the entry at wr_pc's index (non-branch alias hit)
module btb_table
  import core_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int XLEN    = core_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic [XLEN-1:0] wr_target,
  input  logic            wr_inval
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;

  // Instructions are word aligned, so the low two PC bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign rd_tag = rd_pc[XLEN-1:IDX_W+2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign wr_tag = wr_pc[XLEN-1:IDX_W+2];

  // Fetch-side lookup reads the stored state directly, so a write to the same
  // index in this cycle only becomes visible on the following cycle.
  always_comb begin
    rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_taken  = rd_hit && ctr_q[rd_idx][1];
    rd_target = rd_hit ? target_q[rd_idx] : '0;
  end

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Training: a hit nudges the counter toward the outcome and refreshes the
  // target on taken; a taken miss allocates over whatever lived there, starting
  // weakly taken; a not-taken miss leaves the table alone. Invalidation only
  // arrives for non-branches, so it never collides with a branch update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= wr_taken ? sat_inc2(ctr_q[wr_idx]) : sat_dec2(ctr_q[wr_idx]);
        if (wr_taken) begin
          target_q[wr_idx] <= wr_target;
        end
      end else if (wr_taken) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= wr_target;
        ctr_q[wr_idx]    <= WT;
      end
    end else if (wr_inval) begin
      valid_q[wr_idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl
// Dynamic branch prediction controller beside the PC register.
// IF: predicts direction/target for if_pc from the BTB.
// EX: checks the resolved branch against the prediction carried down the pipe,
//     requests a flush with the corrected PC, and trains the BTB.
// Also keeps saturating counts of resolved branches and issued flushes.
// Ports:
//   clk, rstn                     : clock and async active-low reset
//   if_pc                         : PC being fetched
//   pred_taken, pred_target       : IF prediction
//   ex_valid, ex_is_branch, ex_pc : EX instruction qualifiers
//   ex_taken, ex_target           : resolved outcome
//   ex_pred_taken, ex_pred_target : prediction made when it was fetched
//   predict_flush, redirect_pc    : squash IF/ID and restart at redirect_pc
//   branch_cnt, mispredict_cnt    : statistics
module branch_predict_ctrl
  import core_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int XLEN    = core_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            predict_flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispredict_cnt
);

  logic ex_branch;
  logic dir_miss;
  logic tgt_miss;
  logic alias_hit;
  logic flush_raw;

  btb_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .XLEN    (XLEN)
  ) u_btb (
    .clk       (clk),
    .rstn      (rstn),
    .rd_pc     (if_pc),
    .rd_taken  (pred_taken),
    .rd_target (pred_target),
    .wr_en     (ex_branch),
    .wr_pc     (ex_pc),
    .wr_taken  (ex_taken),
    .wr_target (ex_target),
    .wr_inval  (alias_hit)
  );

  // Three ways a prediction can be wrong: wrong direction, right direction but
  // wrong target, or a non-branch that fetched as a predicted-taken branch
  // because it aliased onto a BTB entry. Flush is held off while in reset.
  always_comb begin
    ex_branch = ex_valid && ex_is_branch;
    dir_miss  = ex_branch && (ex_taken != ex_pred_taken);
    tgt_miss  = ex_branch && ex_taken && ex_pred_taken && (ex_target != ex_pred_target);
    alias_hit = ex_valid && !ex_is_branch && ex_pred_taken;
    flush_raw = dir_miss || tgt_miss || alias_hit;

    predict_flush = rstn && flush_raw;
    redirect_pc   = '0;
    if (predict_flush) begin
      redirect_pc = (ex_is_branch && ex_taken) ? ex_target
                                               : ex_pc + {{(XLEN-3){1'b0}}, 3'd4};
    end
  end

  // Statistics stick at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (ex_branch && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (predict_flush && (mispredict_cnt != '1)) begin
        mispredict_cnt <= mispredict_cnt + 32'd1;
      end
    end
  end

endmodule
